// File: rtl/dmem_port_if.sv
// Bundle of the data-memory arbiter's requester and memory buses.
// The slave modport is the arbiter. The master modport is the core, accelerator and memory side.
interface dmem_port_if #(
  parameter int AW = 32
);
  // Zero-latency request/grant. A requester raises req and holds we/addr/wdata
  // stable. A core access completes in a cycle where req && !stall. An
  // accelerator beat completes in a cycle where acc_req && acc_gnt. Read data
  // returns exactly one cycle later, flagged by that requester's rvalid.
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdata;
  logic [3:0]    core_wmask;
  logic          core_flush;
  logic          core_stall;
  logic          core_rvalid;
  logic [31:0]   core_rdata;

  logic          acc_req;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_gnt;
  logic          acc_rvalid;
  logic [31:0]   acc_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_rdata;

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_wmask, core_flush,
    input  core_stall, core_rvalid, core_rdata,
    output acc_req, acc_we, acc_addr, acc_wdata,
    input  acc_gnt, acc_rvalid, acc_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_wmask, core_flush,
    output core_stall, core_rvalid, core_rdata,
    input  acc_req, acc_we, acc_addr, acc_wdata,
    output acc_gnt, acc_rvalid, acc_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter: the core has priority, and a starvation counter
// forces an accelerator beat. The arbiter routes one-cycle read returns to the issuing requester.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  dmem_port_if.slave                         bus,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] dbg_wait_cnt,
  output logic [1:0]                         dbg_grant,
  output logic                               dbg_rd_pend,
  output logic                               dbg_rd_owner
);
  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_CORE = 2'd1;
  localparam logic [1:0] GNT_ACC  = 2'd2;

  logic [CW-1:0] wait_cnt;
  logic          rd_pend;
  logic          rd_owner;
  logic          creq;
  logic          force_acc;
  logic [1:0]    grant;
  logic          core_wins;
  logic          acc_wins;
  logic          rd_grant;
  logic [AW-1:0] addr_mux;

  // The starvation force outranks the core, and a flushed core never competes.
  always_comb begin
    creq      = bus.core_req && !bus.core_flush;
    force_acc = bus.acc_req && (wait_cnt == LIMIT);
    grant     = GNT_NONE;
    if (reset)            grant = GNT_NONE;
    else if (force_acc)   grant = GNT_ACC;
    else if (creq)        grant = GNT_CORE;
    else if (bus.acc_req) grant = GNT_ACC;
  end

  assign core_wins = (grant == GNT_CORE);
  assign acc_wins  = (grant == GNT_ACC);
  assign rd_grant  = (core_wins && !bus.core_we) || (acc_wins && !bus.acc_we);

  assign bus.acc_gnt    = acc_wins;
  assign bus.core_stall = !reset && creq && !core_wins;

  always_comb begin
    bus.mem_en    = (grant != GNT_NONE);
    bus.mem_we    = 1'b0;
    addr_mux      = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    case (grant)
      GNT_CORE: begin
        bus.mem_we    = bus.core_we;
        addr_mux      = bus.core_addr;
        bus.mem_wdata = bus.core_wdata;
        bus.mem_wmask = bus.core_wmask;
      end
      GNT_ACC: begin
        bus.mem_we    = bus.acc_we;
        addr_mux      = bus.acc_addr;
        bus.mem_wdata = bus.acc_wdata;
        bus.mem_wmask = 4'hF;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr = addr_mux;

  // The counter holds at LIMIT until the accelerator is actually granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!bus.acc_req || acc_wins) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= rd_grant;
      if (rd_grant) rd_owner <= acc_wins;
    end
  end

  // Masking with reset drops a return that was in flight when reset arrived.
  assign bus.core_rvalid = !reset && rd_pend && !rd_owner;
  assign bus.acc_rvalid  = !reset && rd_pend && rd_owner;
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.acc_rdata   = bus.mem_rdata;

  assign dbg_wait_cnt = reset ? '0 : wait_cnt;
  assign dbg_grant    = grant;
  assign dbg_rd_pend  = rd_pend;
  assign dbg_rd_owner = rd_owner;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a synchronous memory model and
// read-return scoreboard queues.
module tb_dmem_port_arbiter;
  localparam int AW    = 32;
  localparam int LIMIT = 4;
  localparam int CW    = $clog2(LIMIT + 1);

  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_CORE = 2'd1;
  localparam logic [1:0] W_ACC  = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [CW-1:0] dbg_wait_cnt;
  logic [1:0]    dbg_grant;
  logic          dbg_rd_pend;
  logic          dbg_rd_owner;

  dmem_port_if #(.AW(AW)) bus();

  dmem_port_arbiter #(.STARVE_LIMIT(LIMIT), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .dbg_wait_cnt (dbg_wait_cnt),
    .dbg_grant    (dbg_grant),
    .dbg_rd_pend  (dbg_rd_pend),
    .dbg_rd_owner (dbg_rd_owner)
  );

  // synchronous single-port memory
  logic [31:0] mem [0:255];

  function automatic logic [7:0] widx(input logic [AW-1:0] a);
    return a[9:2];
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask[b]) mem[widx(bus.mem_addr)][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= mem[widx(bus.mem_addr)];
      end
    end
  end

  // scoreboard
  logic [31:0] core_exp_q[$];
  logic [31:0] acc_exp_q[$];
  logic cur_core_rv = 1'b0, cur_acc_rv = 1'b0;
  logic nxt_core_rv = 1'b0, nxt_acc_rv = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_core(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask, input logic flush);
    bus.core_req   = req;
    bus.core_we    = we;
    bus.core_addr  = addr;
    bus.core_wdata = wdata;
    bus.core_wmask = wmask;
    bus.core_flush = flush;
  endtask

  task automatic set_acc(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [31:0] wdata);
    bus.acc_req   = req;
    bus.acc_we    = we;
    bus.acc_addr  = addr;
    bus.acc_wdata = wdata;
  endtask

  task automatic idle();
    set_core(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    set_acc(1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_returns(input string tag);
    logic [31:0] e;
    chk1({tag, "_core_rvalid"}, bus.core_rvalid, cur_core_rv);
    chk1({tag, "_acc_rvalid"}, bus.acc_rvalid, cur_acc_rv);
    if (cur_core_rv) begin
      e = (core_exp_q.size() > 0) ? core_exp_q.pop_front() : 32'hBAD0_BAD0;
      chk32({tag, "_core_rdata"}, bus.core_rdata, e);
    end
    if (cur_acc_rv) begin
      e = (acc_exp_q.size() > 0) ? acc_exp_q.pop_front() : 32'hBAD0_BAD0;
      chk32({tag, "_acc_rdata"}, bus.acc_rdata, e);
    end
  endtask

  // Called right after a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag, input logic [1:0] win);
    logic exp_stall;
    #1;
    if (reset) begin
      cur_core_rv = 1'b0;
      cur_acc_rv  = 1'b0;
      core_exp_q.delete();
      acc_exp_q.delete();
    end
    check_returns(tag);
    exp_stall = !reset && bus.core_req && !bus.core_flush && (win != W_CORE);
    chk1({tag, "_mem_en"}, bus.mem_en, win != W_NONE);
    chk1({tag, "_acc_gnt"}, bus.acc_gnt, win == W_ACC);
    chk1({tag, "_core_stall"}, bus.core_stall, exp_stall);
    chk32({tag, "_dbg_grant"}, 32'(dbg_grant), 32'(win));
    case (win)
      W_CORE: begin
        chk1({tag, "_mem_we"}, bus.mem_we, bus.core_we);
        chk32({tag, "_mem_addr"}, bus.mem_addr, bus.core_addr);
        if (bus.core_we) begin
          chk32({tag, "_mem_wdata"}, bus.mem_wdata, bus.core_wdata);
          chk32({tag, "_mem_wmask"}, 32'(bus.mem_wmask), 32'(bus.core_wmask));
        end else begin
          core_exp_q.push_back(mem[widx(bus.core_addr)]);
          nxt_core_rv = 1'b1;
        end
      end
      W_ACC: begin
        chk1({tag, "_mem_we"}, bus.mem_we, bus.acc_we);
        chk32({tag, "_mem_addr"}, bus.mem_addr, bus.acc_addr);
        if (bus.acc_we) begin
          chk32({tag, "_mem_wdata"}, bus.mem_wdata, bus.acc_wdata);
          chk32({tag, "_mem_wmask"}, 32'(bus.mem_wmask), 32'h0000_000F);
        end else begin
          acc_exp_q.push_back(mem[widx(bus.acc_addr)]);
          nxt_acc_rv = 1'b1;
        end
      end
      default: begin
        chk1({tag, "_mem_we"}, bus.mem_we, 1'b0);
        chk32({tag, "_mem_wmask"}, 32'(bus.mem_wmask), 32'h0);
      end
    endcase
    @(negedge clk);
    cur_core_rv = nxt_core_rv;
    cur_acc_rv  = nxt_acc_rv;
    nxt_core_rv = 1'b0;
    nxt_acc_rv  = 1'b0;
  endtask

  logic [1:0] win_seq [12] = '{W_CORE, W_CORE, W_CORE, W_CORE, W_ACC,
                               W_CORE, W_CORE, W_CORE, W_CORE, W_ACC, W_CORE, W_CORE};
  int         wc_seq  [12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};

  initial begin
    logic [AW-1:0] aaddr;
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    mem[64] = 32'hDEAD_BEEF;
    idle();
    reset = 1'b1;
    @(negedge clk);

    // reset suppresses grants even with both requesters active
    set_core(1'b1, 1'b0, 32'h100, '0, 4'h0, 1'b0);
    set_acc(1'b1, 1'b0, 32'h200, '0);
    step("rst0", W_NONE);
    chk32("rst_wait_cnt", 32'(dbg_wait_cnt), 32'd0);
    step("rst1", W_NONE);
    chk1("rst_rd_pend", dbg_rd_pend, 1'b0);
    chk1("rst_rd_owner", dbg_rd_owner, 1'b0);
    reset = 1'b0;
    idle();
    step("idle0", W_NONE);

    // core-only load
    set_core(1'b1, 1'b0, 32'h100, '0, 4'h0, 1'b0);
    step("cload", W_CORE);
    idle();
    #1 chk32("cload_data", bus.core_rdata, 32'hDEAD_BEEF);
    step("cload_ret", W_NONE);

    // accelerator-only stream of 8 reads
    for (int i = 0; i < 8; i++) begin
      set_acc(1'b1, 1'b0, 32'h200 + 32'(4 * i), '0);
      step("astream", W_ACC);
    end
    idle();
    step("astream_ret", W_NONE);

    // full contention; the 4th->5th cycle is core 0x100 then forced acc 0x104
    aaddr = 32'h104;
    for (int i = 0; i < 12; i++) begin
      set_core(1'b1, 1'b0, 32'h100, '0, 4'h0, 1'b0);
      set_acc(1'b1, 1'b0, aaddr, '0);
      chk32("cont_wait_cnt", 32'(dbg_wait_cnt), 32'(wc_seq[i]));
      step("cont", win_seq[i]);
      if (win_seq[i] == W_ACC) aaddr = aaddr + 32'd4;
    end
    idle();
    step("cont_ret", W_NONE);
    chk32("cont_clear", 32'(dbg_wait_cnt), 32'd0);

    // flush coinciding with a forced accelerator write
    for (int i = 0; i < 4; i++) begin
      set_core(1'b1, 1'b0, 32'h100, '0, 4'h0, 1'b0);
      set_acc(1'b1, 1'b1, 32'h300, 32'hCAFE_F00D);
      step("pre_flush", W_CORE);
    end
    chk32("force_wait_cnt", 32'(dbg_wait_cnt), 32'd4);
    set_core(1'b1, 1'b1, 32'h104, 32'h0, 4'hF, 1'b1);
    step("flush_force", W_ACC);
    chk32("flush_force_cnt", 32'(dbg_wait_cnt), 32'd0);
    chk32("acc_write_mem", mem[192], 32'hCAFE_F00D);
    idle();
    step("flush_ret", W_NONE);

    // flushed store with no accelerator request leaves memory untouched
    set_core(1'b1, 1'b1, 32'h108, 32'h1111_1111, 4'hF, 1'b1);
    step("flush_store", W_NONE);
    idle();
    chk32("flush_store_mem", mem[66], 32'hC0DE_0042);
    step("flush_store_idle", W_NONE);

    // masked core store
    set_core(1'b1, 1'b1, 32'h10C, 32'h1234_5678, 4'b0011, 1'b0);
    step("mstore", W_CORE);
    idle();
    chk32("mstore_mem", mem[67], 32'hC0DE_5678);
    step("mstore_idle", W_NONE);

    // reset arriving while a core read is outstanding
    set_core(1'b1, 1'b0, 32'h100, '0, 4'h0, 1'b0);
    step("rmr_read", W_CORE);
    idle();
    reset = 1'b1;
    step("rmr_rst", W_NONE);
    reset = 1'b0;
    step("rmr_after", W_NONE);
    chk1("rmr_rd_pend", dbg_rd_pend, 1'b0);
    chk32("rmr_wait_cnt", 32'(dbg_wait_cnt), 32'd0);
    set_core(1'b1, 1'b0, 32'h100, '0, 4'h0, 1'b0);
    set_acc(1'b1, 1'b0, 32'h200, '0);
    step("rmr_cont", W_CORE);
    idle();
    step("rmr_ret", W_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single-ported data memory between the core's memory stage (load/store unit) and the GEMM accelerator's operand/result DMA port. Grants at most one access per cycle. The core has priority, subject to a starvation guard that forces an accelerator beat after a bounded wait. It raises `core_stall` toward the hazard logic whenever a core access loses arbitration, and routes the one-cycle-latency read data back to whichever requester issued the read.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive denied accelerator-request cycles after which the accelerator wins the next cycle; legal range 1..255.
- `AW`, default 32: address width (byte address).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset; one clock, synchronous, active-high.
- `core_req` in 1: core memory-stage access valid (load or store).
- `core_we` in 1: 1 = store, 0 = load.
- `core_addr` in AW: core byte address.
- `core_wdata` in 32: store data.
- `core_wmask` in 4: store byte enables.
- `core_flush` in 1: kill the core access this cycle (branch/interrupt flush).
- `core_stall` out 1: core access not granted this cycle; core must hold its request.
- `core_rvalid` out 1: core load data valid.
- `core_rdata` out 32: core load data.
- `acc_req` in 1: accelerator beat request; held until granted.
- `acc_we` in 1: 1 = write, 0 = read.
- `acc_addr` in AW: accelerator byte address.
- `acc_wdata` in 32: accelerator write data (full word, mask 4'hF).
- `acc_gnt` out 1: accelerator beat accepted this cycle.
- `acc_rvalid` out 1: accelerator read data valid.
- `acc_rdata` out 32: accelerator read data.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write.
- `mem_addr` out AW: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_wmask` out 4: memory byte enables.
- `mem_rdata` in 32: synchronous-read data, valid one cycle after `mem_en && !mem_we`.

## Operation
- Effective core request: `creq = core_req && !core_flush`.
- Grant decision (combinational, per cycle):
  - `force_acc = acc_req && (wait_cnt == STARVE_LIMIT)`.
  - If `force_acc`, the accelerator wins.
  - Else if `creq`, the core wins.
  - Else if `acc_req`, the accelerator wins.
  - Otherwise no grant.
- `acc_gnt` = accelerator wins.
- `core_stall = creq && !core_wins`. `core_flush` forces `core_stall=0`.
- Memory outputs mux the winner's `we/addr/wdata/wmask`; `mem_en` = any grant.
- With no grant, `mem_we=0`, `mem_wmask=0`, and `mem_addr`/`mem_wdata` are don't-care.
- Starvation counter `wait_cnt`:
  - `$clog2(STARVE_LIMIT+1)` bits.
  - Increments when `acc_req && !acc_gnt`, saturating at `STARVE_LIMIT`.
  - Clears on `acc_gnt` or on `!acc_req`.
- Read-return tracking: registered `rd_pend` (1 bit) and `rd_owner` (0 = core, 1 = accelerator).
  - Both are set on any granted read.
  - `rd_pend` clears otherwise.
  - `core_rvalid = rd_pend && !rd_owner`; `acc_rvalid = rd_pend && rd_owner`.
  - `core_rdata` and `acc_rdata` both pass `mem_rdata` directly.
- Writes produce no return.
- Back-to-back reads from alternating owners must route correctly every cycle.

## Timing
- Grant latency: 0 cycles. A request and its grant occur in the same cycle.
- Read latency: exactly 1 cycle after the grant.
- The arbiter does not buffer. Requesters hold `req/we/addr/wdata` stable until granted.
- Reset (synchronous), in the reset cycle and the next cycle:
  - `wait_cnt=0`, `rd_pend=0`, `rd_owner=0`.
  - All grants are suppressed while `reset` is high: `mem_en=0`, `acc_gnt=0`, `core_stall=0`.
  - `core_rvalid=0`, `acc_rvalid=0`.
- Reset during an outstanding read: the read return is dropped. No `rvalid` fires in the following cycle.
- Starvation bound: with `core_req` held continuously, an asserted `acc_req` is granted within `STARVE_LIMIT+1` cycles. On that cycle `core_stall=1`.
- `STARVE_LIMIT=1`: the accelerator and the core alternate under full contention.
- Simultaneous `core_flush` and `force_acc`: the accelerator is granted and `core_stall=0`.
- A flushed cycle does not increment `wait_cnt` if the accelerator was granted.

## Test plan
- **Core-only load:** `core_req=1`, `core_we=0`, `core_addr=0x100`, memory holds `0xDEADBEEF` → `mem_en=1` and `core_stall=0` the same cycle. Next cycle `core_rvalid=1`, `core_rdata=0xDEADBEEF`, `acc_rvalid=0`.
- **Accelerator-only stream:** 8 consecutive reads at 0x200..0x21C, core idle → `acc_gnt=1` every cycle. `acc_rvalid` is high for 8 cycles, lagging by 1, with data in address order.
- **Contention, `STARVE_LIMIT=4`:** `core_req` and `acc_req` both held high for 12 cycles → grant pattern C,C,C,C,A,C,C,C,C,A,C,C. `core_stall=1` exactly on the A cycles. `wait_cnt` peaks at 4.
- **Alternating-owner read return:** core read of 0x100 in cycle n, accelerator read of 0x104 in cycle n+1 (via force) → `core_rvalid` at n+1 and `acc_rvalid` at n+2, each with the correct word and no cross-routing.
- **Flush:** `core_req=1` and `core_flush=1` with `acc_req=1` → `acc_gnt=1`, `core_stall=0`, `mem_addr=acc_addr`. Core store with flush and no accelerator request → `mem_en=0`, memory unchanged.
- **Reset mid-read:** grant a core read at cycle n, assert `reset` at n+1 → `core_rvalid=0` at n+1 and n+2. After deassert, `wait_cnt=0`, and the first contention cycle grants the core.
